// File: rtl/ddr_axi4_responder.sv
// ddr_axi4_responder: AXI4 subordinate backed by an on-chip dual-port RAM, standing in for a DDR controller.
// Optional feature macro: DDR_RESP_WRAP_EN enables WRAP bursts (len+1 in {2,4,8,16}); otherwise WRAP beats get SLVERR.

module ddr_axi4_responder #(
  parameter int                ID_W           = 6,
  parameter int                ADDR_W         = 64,
  parameter int                DATA_W         = 512,
  parameter int                MEM_WORDS_LOG2 = 12,
  parameter logic [ADDR_W-1:0] BASE_ADDR      = {ADDR_W{1'b0}}
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  awvalid,
  output logic                  awready,
  input  logic [ID_W-1:0]       awid,
  input  logic [ADDR_W-1:0]     awaddr,
  input  logic [7:0]            awlen,
  input  logic [2:0]            awsize,
  input  logic [1:0]            awburst,
  input  logic [3:0]            awcache,
  input  logic                  awlock,
  input  logic [2:0]            awprot,
  input  logic [3:0]            awqos,
  input  logic [3:0]            awregion,
  input  logic                  wvalid,
  output logic                  wready,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [DATA_W/8-1:0]   wstrb,
  input  logic                  wlast,
  output logic                  bvalid,
  input  logic                  bready,
  output logic [ID_W-1:0]       bid,
  output logic [1:0]            bresp,
  input  logic                  arvalid,
  output logic                  arready,
  input  logic [ID_W-1:0]       arid,
  input  logic [ADDR_W-1:0]     araddr,
  input  logic [7:0]            arlen,
  input  logic [2:0]            arsize,
  input  logic [1:0]            arburst,
  input  logic [3:0]            arcache,
  input  logic                  arlock,
  input  logic [2:0]            arprot,
  input  logic [3:0]            arqos,
  input  logic [3:0]            arregion,
  output logic                  rvalid,
  input  logic                  rready,
  output logic [ID_W-1:0]       rid,
  output logic [DATA_W-1:0]     rdata,
  output logic [1:0]            rresp,
  output logic                  rlast
);

  localparam int STRB_W = DATA_W / 8;
  localparam int FULL   = $clog2(STRB_W);
  localparam int DEPTH  = 1 << MEM_WORDS_LOG2;
  localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] WIN_BYTES = ADDR_ONE << (MEM_WORDS_LOG2 + FULL);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] BURST_RSVD  = 2'b11;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} r_state_e;

  // Top bit of the result is the borrow: set when addr lies below BASE_ADDR.
  function automatic logic [ADDR_W:0] addr_offset(input logic [ADDR_W-1:0] addr);
    return {1'b0, addr} - {1'b0, BASE_ADDR};
  endfunction

  function automatic logic [MEM_WORDS_LOG2-1:0] word_idx(input logic [ADDR_W-1:0] addr);
    return MEM_WORDS_LOG2'(addr_offset(addr) >> FULL);
  endfunction

  function automatic logic [1:0] beat_err(input logic [ADDR_W-1:0] addr, input logic [2:0] size,
                                          input logic [1:0] burst, input logic wrap_ok);
    logic [ADDR_W:0] off;
    logic [1:0]      res;
    off = addr_offset(addr);
    if (off[ADDR_W] || (off[ADDR_W-1:0] >= WIN_BYTES)) begin
      res = RESP_DECERR;
    end else if ((size != 3'(FULL)) || (burst == BURST_RSVD) || ((burst == BURST_WRAP) && !wrap_ok)) begin
      res = RESP_SLVERR;
    end else begin
      res = RESP_OKAY;
    end
    return res;
  endfunction

  // Response codes are ordered so that the numerically larger one is the worse one.
  function automatic logic [1:0] worse(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] addr, input logic [2:0] size,
                                                  input logic [1:0] burst, input logic [7:0] len);
    logic [ADDR_W-1:0] inc;
    logic [ADDR_W-1:0] mask;
    logic [ADDR_W-1:0] res;
    inc  = ADDR_ONE << size;
    mask = (({{(ADDR_W-8){1'b0}}, len} + ADDR_ONE) << size) - ADDR_ONE;
    case (burst)
      BURST_FIXED: res = addr;
      BURST_WRAP:  res = (addr & ~mask) | ((addr + inc) & mask);
      default:     res = addr + inc;
    endcase
    return res;
  endfunction

`ifdef DDR_RESP_WRAP_EN
  function automatic logic wrap_len_legal(input logic [7:0] len);
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction
`endif

  logic [DATA_W-1:0] mem_r [DEPTH];

  w_state_e            w_state_r, w_state_nxt_s;
  logic [ID_W-1:0]     aw_id_r;
  logic [ADDR_W-1:0]   aw_addr_r;
  logic [7:0]          aw_len_r;
  logic [2:0]          aw_size_r;
  logic [1:0]          aw_burst_r;
  logic [7:0]          w_beat_r;
  logic [1:0]          w_err_r;
  logic                awready_r, wready_r, bvalid_r;
  logic [ID_W-1:0]     bid_r;
  logic [1:0]          bresp_r;
  logic                aw_hs_s, w_hs_s, w_last_beat_s, w_wrap_ok_s, mem_we_s;
  logic [1:0]          w_beat_err_s, w_err_nxt_s;
  logic [MEM_WORDS_LOG2-1:0] w_idx_s;

  r_state_e            r_state_r, r_state_nxt_s;
  logic [ID_W-1:0]     ar_id_r;
  logic [ADDR_W-1:0]   ar_addr_r;
  logic [7:0]          ar_len_r;
  logic [2:0]          ar_size_r;
  logic [1:0]          ar_burst_r;
  logic [7:0]          r_beat_r;
  logic                arready_r, rvalid_r, rlast_r;
  logic [ID_W-1:0]     rid_r;
  logic [1:0]          rresp_r;
  logic [DATA_W-1:0]   rdata_r;
  logic                ar_hs_s, r_last_beat_s, r_wrap_ok_s;
  logic [1:0]          r_beat_err_s;
  logic [MEM_WORDS_LOG2-1:0] r_idx_s;

  logic unused_s;
  assign unused_s = ^{awcache, awlock, awprot, awqos, awregion, arcache, arlock, arprot, arqos, arregion};

`ifdef DDR_RESP_WRAP_EN
  assign w_wrap_ok_s = wrap_len_legal(aw_len_r);
  assign r_wrap_ok_s = wrap_len_legal(ar_len_r);
`else
  assign w_wrap_ok_s = 1'b0;
  assign r_wrap_ok_s = 1'b0;
`endif

  assign aw_hs_s       = awvalid && awready_r;
  assign w_hs_s        = wvalid && wready_r;
  assign w_last_beat_s = (w_beat_r == aw_len_r);
  assign w_beat_err_s  = beat_err(aw_addr_r, aw_size_r, aw_burst_r, w_wrap_ok_s);
  assign w_idx_s       = word_idx(aw_addr_r);
  assign w_err_nxt_s   = worse(worse(w_err_r, w_beat_err_s), (wlast != w_last_beat_s) ? RESP_SLVERR : RESP_OKAY);
  assign mem_we_s      = resetn && (w_state_r == W_DATA) && w_hs_s && (w_beat_err_s == RESP_OKAY);

  assign ar_hs_s       = arvalid && arready_r;
  assign r_last_beat_s = (r_beat_r == ar_len_r);
  assign r_beat_err_s  = beat_err(ar_addr_r, ar_size_r, ar_burst_r, r_wrap_ok_s);
  assign r_idx_s       = word_idx(ar_addr_r);

  // Write engine next-state logic.
  always_comb begin
    w_state_nxt_s = w_state_r;
    case (w_state_r)
      W_IDLE: begin
        if (aw_hs_s) w_state_nxt_s = W_DATA;
        else         w_state_nxt_s = W_IDLE;
      end
      W_DATA: begin
        if (w_hs_s && w_last_beat_s) w_state_nxt_s = W_RESP;
        else                         w_state_nxt_s = W_DATA;
      end
      W_RESP: begin
        if (bvalid_r && bready) w_state_nxt_s = W_IDLE;
        else                    w_state_nxt_s = W_RESP;
      end
      default: w_state_nxt_s = W_IDLE;
    endcase
  end

  // Write engine state, captured AW fields and registered AW/W/B outputs.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      w_state_r  <= W_IDLE;
      awready_r  <= 1'b0;
      wready_r   <= 1'b0;
      bvalid_r   <= 1'b0;
      bid_r      <= {ID_W{1'b0}};
      bresp_r    <= RESP_OKAY;
      aw_id_r    <= {ID_W{1'b0}};
      aw_addr_r  <= {ADDR_W{1'b0}};
      aw_len_r   <= 8'd0;
      aw_size_r  <= 3'd0;
      aw_burst_r <= 2'd0;
      w_beat_r   <= 8'd0;
      w_err_r    <= RESP_OKAY;
    end else begin
      w_state_r <= w_state_nxt_s;
      awready_r <= (w_state_nxt_s == W_IDLE);
      wready_r  <= (w_state_nxt_s == W_DATA);
      bvalid_r  <= (w_state_nxt_s == W_RESP);
      case (w_state_r)
        W_IDLE: begin
          if (aw_hs_s) begin
            aw_id_r    <= awid;
            aw_addr_r  <= awaddr;
            aw_len_r   <= awlen;
            aw_size_r  <= awsize;
            aw_burst_r <= awburst;
            w_beat_r   <= 8'd0;
            w_err_r    <= RESP_OKAY;
          end
        end
        W_DATA: begin
          if (w_hs_s) begin
            aw_addr_r <= next_addr(aw_addr_r, aw_size_r, aw_burst_r, aw_len_r);
            w_beat_r  <= w_beat_r + 8'd1;
            w_err_r   <= w_err_nxt_s;
            if (w_last_beat_s) begin
              bid_r   <= aw_id_r;
              bresp_r <= w_err_nxt_s;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Byte-masked RAM write port; the array itself is never reset.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      for (int i = 0; i < STRB_W; i++) begin
        if (wstrb[i]) mem_r[w_idx_s][i*8 +: 8] <= wdata[i*8 +: 8];
      end
    end
  end

  // Read engine next-state logic.
  always_comb begin
    r_state_nxt_s = r_state_r;
    case (r_state_r)
      R_IDLE: begin
        if (ar_hs_s) r_state_nxt_s = R_FETCH;
        else         r_state_nxt_s = R_IDLE;
      end
      R_FETCH: r_state_nxt_s = R_DATA;
      R_DATA: begin
        if (rvalid_r && rready) r_state_nxt_s = r_last_beat_s ? R_IDLE : R_FETCH;
        else                    r_state_nxt_s = R_DATA;
      end
      default: r_state_nxt_s = R_IDLE;
    endcase
  end

  // Read engine state, RAM read port (read-first against the write port) and registered AR/R outputs.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state_r  <= R_IDLE;
      arready_r  <= 1'b0;
      rvalid_r   <= 1'b0;
      rlast_r    <= 1'b0;
      rid_r      <= {ID_W{1'b0}};
      rresp_r    <= RESP_OKAY;
      rdata_r    <= {DATA_W{1'b0}};
      ar_id_r    <= {ID_W{1'b0}};
      ar_addr_r  <= {ADDR_W{1'b0}};
      ar_len_r   <= 8'd0;
      ar_size_r  <= 3'd0;
      ar_burst_r <= 2'd0;
      r_beat_r   <= 8'd0;
    end else begin
      r_state_r <= r_state_nxt_s;
      arready_r <= (r_state_nxt_s == R_IDLE);
      rvalid_r  <= (r_state_nxt_s == R_DATA);
      case (r_state_r)
        R_IDLE: begin
          if (ar_hs_s) begin
            ar_id_r    <= arid;
            ar_addr_r  <= araddr;
            ar_len_r   <= arlen;
            ar_size_r  <= arsize;
            ar_burst_r <= arburst;
            r_beat_r   <= 8'd0;
          end
        end
        R_FETCH: begin
          rdata_r <= (r_beat_err_s == RESP_OKAY) ? mem_r[r_idx_s] : {DATA_W{1'b0}};
          rresp_r <= r_beat_err_s;
          rlast_r <= r_last_beat_s;
          rid_r   <= ar_id_r;
        end
        R_DATA: begin
          if (rvalid_r && rready && !r_last_beat_s) begin
            ar_addr_r <= next_addr(ar_addr_r, ar_size_r, ar_burst_r, ar_len_r);
            r_beat_r  <= r_beat_r + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign awready = awready_r;
  assign wready  = wready_r;
  assign bvalid  = bvalid_r;
  assign bid     = bid_r;
  assign bresp   = bresp_r;
  assign arready = arready_r;
  assign rvalid  = rvalid_r;
  assign rid     = rid_r;
  assign rdata   = rdata_r;
  assign rresp   = rresp_r;
  assign rlast   = rlast_r;

endmodule

// File: tb/tb_ddr_axi4_responder.sv
// Scoreboard bench for ddr_axi4_responder: directed bursts push expected B/R responses,
// a negedge monitor pops and compares them on every handshake.

module tb_ddr_axi4_responder;

  localparam logic [63:0]  B       = 64'h0000_0000_1000_0000;
  localparam logic [63:0]  WIN     = 64'h0000_0000_0004_0000;
  localparam logic [63:0]  ALL     = {64{1'b1}};
  localparam logic [1:0]   OKAY    = 2'b00;
  localparam logic [1:0]   SLVERR  = 2'b10;
  localparam logic [1:0]   DECERR  = 2'b11;
  localparam logic [1:0]   FIXED   = 2'b00;
  localparam logic [1:0]   INCR    = 2'b01;
  localparam logic [1:0]   WRAP    = 2'b10;
  localparam logic [511:0] ZERO    = {512{1'b0}};
  localparam logic [511:0] ONES    = {512{1'b1}};

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic awvalid = 1'b0, awready, awlock = 1'b0;
  logic [5:0] awid = 6'd0;
  logic [63:0] awaddr = 64'd0;
  logic [7:0] awlen = 8'd0;
  logic [2:0] awsize = 3'd0, awprot = 3'd0;
  logic [1:0] awburst = 2'd0;
  logic [3:0] awcache = 4'd0, awqos = 4'd0, awregion = 4'd0;
  logic wvalid = 1'b0, wready, wlast = 1'b0;
  logic [511:0] wdata = 512'd0;
  logic [63:0] wstrb = 64'd0;
  logic bvalid, bready = 1'b0;
  logic [5:0] bid;
  logic [1:0] bresp;
  logic arvalid = 1'b0, arready, arlock = 1'b0;
  logic [5:0] arid = 6'd0;
  logic [63:0] araddr = 64'd0;
  logic [7:0] arlen = 8'd0;
  logic [2:0] arsize = 3'd0, arprot = 3'd0;
  logic [1:0] arburst = 2'd0;
  logic [3:0] arcache = 4'd0, arqos = 4'd0, arregion = 4'd0;
  logic rvalid, rready = 1'b0, rlast;
  logic [5:0] rid;
  logic [511:0] rdata;
  logic [1:0] rresp;

  ddr_axi4_responder #(.ID_W(6), .ADDR_W(64), .DATA_W(512), .MEM_WORDS_LOG2(12), .BASE_ADDR(B)) dut (
    .clk(clk), .resetn(resetn),
    .awvalid(awvalid), .awready(awready), .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
    .awburst(awburst), .awcache(awcache), .awlock(awlock), .awprot(awprot), .awqos(awqos), .awregion(awregion),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .bvalid(bvalid), .bready(bready), .bid(bid), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arcache(arcache), .arlock(arlock), .arprot(arprot), .arqos(arqos), .arregion(arregion),
    .rvalid(rvalid), .rready(rready), .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast)
  );

  initial forever #5 clk = ~clk;

  typedef struct { logic [5:0] id; logic [1:0] resp; } b_exp_t;
  typedef struct { logic [5:0] id; logic [511:0] data; logic [1:0] resp; logic last; } r_exp_t;
  b_exp_t b_q[$];
  r_exp_t r_q[$];

  int vectors = 0;
  int miscompares = 0;
  int ready_mode = 0;  // 0: always ready, 1: random back-pressure, 2: never ready

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_r(input logic [5:0] id, input logic [511:0] data, input logic [1:0] resp, input logic last);
    r_exp_t e;
    e.id = id; e.data = data; e.resp = resp; e.last = last;
    r_q.push_back(e);
  endtask

  initial forever begin
    @(posedge clk);
    #1;
    case (ready_mode)
      0:       begin bready = 1'b1; rready = 1'b1; end
      1:       begin bready = 1'($urandom_range(0, 1)); rready = 1'($urandom_range(0, 1)); end
      default: begin bready = 1'b0; rready = 1'b0; end
    endcase
  end

  // Monitor: every handshake seen at the negedge is compared against the head of its queue.
  initial forever begin
    b_exp_t be;
    r_exp_t re;
    @(negedge clk);
    if (resetn && bvalid && bready) begin
      if (b_q.size() == 0) begin
        vectors++; miscompares++;
        $display("FAIL b_unexpected: got id %0d resp %0d with no expected response", bid, bresp);
      end else begin
        be = b_q.pop_front();
        check("bid", 512'(bid), 512'(be.id));
        check("bresp", 512'(bresp), 512'(be.resp));
      end
    end
    if (resetn && rvalid && rready) begin
      if (r_q.size() == 0) begin
        vectors++; miscompares++;
        $display("FAIL r_unexpected: got id %0d data %h with no expected beat", rid, rdata);
      end else begin
        re = r_q.pop_front();
        check("rid", 512'(rid), 512'(re.id));
        check("rdata", rdata, re.data);
        check("rresp", 512'(rresp), 512'(re.resp));
        check("rlast", 512'(rlast), 512'(re.last));
      end
    end
  end

  task automatic send_aw(input logic [5:0] id, input logic [63:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    int n = 0;
    awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
    @(negedge clk);
    while (!awready && n < 200) begin @(negedge clk); n++; end
    check("aw_accept", 512'(awready), 512'(1'b1));
    @(posedge clk); #1;
    awvalid = 1'b0;
  endtask

  task automatic send_ar(input logic [5:0] id, input logic [63:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    int n = 0;
    arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
    @(negedge clk);
    while (!arready && n < 200) begin @(negedge clk); n++; end
    check("ar_accept", 512'(arready), 512'(1'b1));
    @(posedge clk); #1;
    arvalid = 1'b0;
  endtask

  task automatic send_w(input logic [511:0] data, input logic [63:0] strb, input logic last);
    int n = 0;
    wdata = data; wstrb = strb; wlast = last; wvalid = 1'b1;
    @(negedge clk);
    while (!wready && n < 200) begin @(negedge clk); n++; end
    check("w_accept", 512'(wready), 512'(1'b1));
    @(posedge clk); #1;
    wvalid = 1'b0;
  endtask

  task automatic write_burst(input logic [5:0] id, input logic [63:0] addr, input logic [7:0] len,
                             input logic [2:0] size, input logic [1:0] burst, input logic [511:0] dbase,
                             input logic [63:0] strb, input bit bad_last0, input logic [1:0] exp_resp,
                             input bit gaps);
    b_exp_t e;
    e.id = id; e.resp = exp_resp;
    b_q.push_back(e);
    send_aw(id, addr, len, size, burst);
    for (int k = 0; k <= int'(len); k++) begin
      if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      send_w(dbase + 512'(k), strb, (k == int'(len)) || (bad_last0 && k == 0));
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((b_q.size() != 0 || r_q.size() != 0) && n < 500) begin @(posedge clk); n++; end
    #1;
    check("drain", 512'(b_q.size() + r_q.size()), 512'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_ctrl", 512'({awready, wready, arready, bvalid, rvalid, rlast}), 512'(0));
    check("reset_ids", 512'({bid, bresp, rid, rresp}), 512'(0));
    check("reset_rdata", rdata, ZERO);
    @(posedge clk); #1;
    resetn = 1'b1;

    // INCR write of k=0..3 to words 1..4, then read back.
    write_burst(6'd5, B + 64'h40, 8'd3, 3'd6, INCR, ZERO, ALL, 1'b0, OKAY, 1'b0);
    drain();
    for (int k = 0; k < 4; k++) push_r(6'd9, 512'(k), OKAY, k == 3);
    send_ar(6'd9, B + 64'h40, 8'd3, 3'd6, INCR);
    drain();

    // Partial strobe into word 0.
    write_burst(6'd1, B, 8'd0, 3'd6, INCR, ONES, ALL, 1'b0, OKAY, 1'b0);
    write_burst(6'd2, B, 8'd0, 3'd6, INCR, ZERO, 64'h1, 1'b0, OKAY, 1'b0);
    drain();
    push_r(6'd3, {{504{1'b1}}, 8'h00}, OKAY, 1'b1);
    send_ar(6'd3, B, 8'd0, 3'd6, INCR);
    drain();

    // Out-of-window accesses: just past the top, and just below the base.
    write_burst(6'd4, B + WIN, 8'd0, 3'd6, INCR, 512'h99, ALL, 1'b0, DECERR, 1'b0);
    drain();
    push_r(6'd5, ZERO, DECERR, 1'b0);
    push_r(6'd5, ZERO, DECERR, 1'b1);
    send_ar(6'd5, B + WIN, 8'd1, 3'd6, INCR);
    push_r(6'd6, {{504{1'b1}}, 8'h00}, OKAY, 1'b1);
    send_ar(6'd6, B, 8'd0, 3'd6, INCR);
    push_r(6'd7, ZERO, DECERR, 1'b1);
    send_ar(6'd7, B - 64'h40, 8'd0, 3'd6, INCR);
    drain();

    // Early wlast: both beats still land, burst reports SLVERR.
    write_burst(6'd7, B + 64'h200, 8'd1, 3'd6, INCR, 512'hA, ALL, 1'b1, SLVERR, 1'b0);
    drain();
    push_r(6'd8, ZERO, SLVERR, 1'b1);
    send_ar(6'd8, B + 64'h200, 8'd0, 3'd3, INCR);
    push_r(6'd8, 512'hA, OKAY, 1'b0);
    push_r(6'd8, 512'hB, OKAY, 1'b1);
    send_ar(6'd8, B + 64'h200, 8'd1, 3'd6, INCR);
    push_r(6'd10, ZERO, SLVERR, 1'b1);
    send_ar(6'd10, B + 64'h200, 8'd0, 3'd6, 2'b11);
    drain();

    // FIXED bursts stay on one word.
    write_burst(6'd11, B + 64'h280, 8'd1, 3'd6, FIXED, 512'h11, ALL, 1'b0, OKAY, 1'b0);
    drain();
    push_r(6'd12, 512'h12, OKAY, 1'b0);
    push_r(6'd12, 512'h12, OKAY, 1'b1);
    send_ar(6'd12, B + 64'h280, 8'd1, 3'd6, FIXED);
    drain();

    // WRAP read starting at word 3 of a 4-word block.
`ifdef DDR_RESP_WRAP_EN
    push_r(6'd13, 512'h2, OKAY, 1'b0);
    push_r(6'd13, {{504{1'b1}}, 8'h00}, OKAY, 1'b0);
    push_r(6'd13, 512'h0, OKAY, 1'b0);
    push_r(6'd13, 512'h1, OKAY, 1'b1);
    send_ar(6'd13, B + 64'hC0, 8'd3, 3'd6, WRAP);
    drain();
`else
    for (int k = 0; k < 4; k++) push_r(6'd13, ZERO, SLVERR, k == 3);
    send_ar(6'd13, B + 64'hC0, 8'd3, 3'd6, WRAP);
    write_burst(6'd14, B + 64'h100, 8'd1, 3'd6, WRAP, 512'h5A, ALL, 1'b0, SLVERR, 1'b0);
    drain();
    push_r(6'd15, 512'h3, OKAY, 1'b1);
    send_ar(6'd15, B + 64'h100, 8'd0, 3'd6, INCR);
    drain();
`endif

    // Same-word same-cycle write and read: the read sees the old value.
    write_burst(6'd16, B + 64'h500, 8'd0, 3'd6, INCR, 512'h55, ALL, 1'b0, OKAY, 1'b0);
    drain();
    b_q.push_back('{id: 6'd17, resp: OKAY});
    push_r(6'd18, 512'h55, OKAY, 1'b1);
    send_aw(6'd17, B + 64'h500, 8'd0, 3'd6, INCR);
    arid = 6'd18; araddr = B + 64'h500; arlen = 8'd0; arsize = 3'd6; arburst = INCR; arvalid = 1'b1;
    @(posedge clk); #1;
    arvalid = 1'b0;
    wdata = 512'h66; wstrb = ALL; wlast = 1'b1; wvalid = 1'b1;
    @(posedge clk); #1;
    wvalid = 1'b0;
    drain();
    push_r(6'd19, 512'h66, OKAY, 1'b1);
    send_ar(6'd19, B + 64'h500, 8'd0, 3'd6, INCR);
    drain();

    // Concurrent write and read bursts under random back-pressure.
    ready_mode = 1;
    for (int k = 0; k < 4; k++) push_r(6'd20, 512'(k), OKAY, k == 3);
    fork
      write_burst(6'd21, B + 64'h400, 8'd3, 3'd6, INCR, 512'h100, ALL, 1'b0, OKAY, 1'b1);
      send_ar(6'd20, B + 64'h40, 8'd3, 3'd6, INCR);
    join
    drain();
    for (int k = 0; k < 4; k++) push_r(6'd22, 512'h100 + 512'(k), OKAY, k == 3);
    send_ar(6'd22, B + 64'h400, 8'd3, 3'd6, INCR);
    drain();

    // Reset while a B and an R are both pending.
    ready_mode = 2;
    @(posedge clk); #1;
    send_aw(6'd23, B + 64'h800, 8'd0, 3'd6, INCR);
    send_w(512'h77, ALL, 1'b1);
    send_ar(6'd24, B + 64'h40, 8'd0, 3'd6, INCR);
    begin
      int n = 0;
      @(negedge clk);
      while (!(rvalid && bvalid) && n < 50) begin @(negedge clk); n++; end
      check("pending_before_reset", 512'({bvalid, rvalid}), 512'(2'b11));
    end
    @(posedge clk); #1;
    resetn = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("reset_mid_burst", 512'({bvalid, rvalid, awready, arready}), 512'(0));
    @(posedge clk); #1;
    resetn = 1'b1;
    ready_mode = 0;
    push_r(6'd25, 512'h77, OKAY, 1'b1);
    send_ar(6'd25, B + 64'h800, 8'd0, 3'd6, INCR);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
